// File: rtl/mic1_mem_pkg.sv
// Shared defaults and FSM state types for the MIC-1 memory controller.
package mic1_mem_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 9;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_RD   = 2'd1,
    A_WAIT = 2'd2,
    A_WR   = 2'd3
  } port_a_state_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_PEND = 2'd1,
    B_RD   = 2'd2,
    B_WAIT = 2'd3
  } port_b_state_t;

endpackage

// File: rtl/mem_lat_cnt.sv
// Read-latency down-counter: loaded by start, done while the count is zero.
module mem_lat_cnt #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(RD_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mic1_mem_ctrl.sv
// Turns MIC-1 rd/wr/fetch strobes into timed main_memory port-A/port-B accesses,
// with busy flags, request-error pulses and a fetch-after-write hazard stall.
module mic1_mem_ctrl
  import mic1_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr_in,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] mdr_out,
  output logic              mdr_valid,
  output logic [DATA_W-1:0] mbr_out,
  output logic              mbr_valid,
  output logic              wr_done,
  output logic              busy_a,
  output logic              busy_b,
  output logic              req_err,
  output logic              wen_A,
  output logic              ren_A,
  output logic              ren_B,
  output logic [ADDR_W-1:0] addr_A,
  output logic [ADDR_W-1:0] addr_B,
  output logic [DATA_W-1:0] wdata_A,
  input  logic [DATA_W-1:0] rdata_A,
  input  logic [DATA_W-1:0] rdata_B,
  output port_a_state_t     state_a_dbg,
  output port_b_state_t     state_b_dbg
);

  // Handshake: each *_req is a one-cycle strobe, accepted only when its port
  // is idle (busy_* low); otherwise it is dropped and req_err pulses.

  port_a_state_t state_a;
  port_b_state_t state_b;

  logic lat_a_done;
  logic lat_b_done;
  logic rd_acc;
  logic wr_acc;
  logic fetch_acc;
  logic hazard_new;
  logic hazard_pend;
  logic err_now;

  assign rd_acc    = (state_a == A_IDLE) && rd_req && !wr_req;
  assign wr_acc    = (state_a == A_IDLE) && wr_req && !rd_req;
  assign fetch_acc = (state_b == B_IDLE) && fetch_req;

  // A new fetch conflicts with a write now on the port or one accepted this edge.
  assign hazard_new = ((state_a == A_WR) && (pc == addr_A)) || (wr_acc && (pc == mar));

  // A pending fetch may launch once the blocking write is sampled by memory;
  // only a fresh write to the same address accepted this edge keeps it parked.
  assign hazard_pend = wr_acc && (addr_B == mar);

  assign err_now = (rd_req && wr_req)
                || ((rd_req || wr_req) && (state_a != A_IDLE))
                || (fetch_req && (state_b != B_IDLE));

  mem_lat_cnt #(.RD_LAT(RD_LAT)) u_lat_a (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_a == A_RD),
    .done  (lat_a_done)
  );

  mem_lat_cnt #(.RD_LAT(RD_LAT)) u_lat_b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state_b == B_RD),
    .done  (lat_b_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_a   <= A_IDLE;
      ren_A     <= 1'b0;
      wen_A     <= 1'b0;
      addr_A    <= '0;
      wdata_A   <= '0;
      mdr_out   <= '0;
      mdr_valid <= 1'b0;
      wr_done   <= 1'b0;
    end else begin
      ren_A     <= 1'b0;
      wen_A     <= 1'b0;
      mdr_valid <= 1'b0;
      wr_done   <= 1'b0;
      case (state_a)
        A_IDLE: begin
          if (rd_acc) begin
            state_a <= A_RD;
            ren_A   <= 1'b1;
            addr_A  <= mar;
            wdata_A <= mdr_in;
          end else if (wr_acc) begin
            state_a <= A_WR;
            wen_A   <= 1'b1;
            addr_A  <= mar;
            wdata_A <= mdr_in;
          end
        end
        A_RD: state_a <= A_WAIT;
        A_WAIT: begin
          if (lat_a_done) begin
            state_a   <= A_IDLE;
            mdr_out   <= rdata_A;
            mdr_valid <= 1'b1;
          end
        end
        A_WR: begin
          state_a <= A_IDLE;
          wr_done <= 1'b1;
        end
        default: state_a <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_b   <= B_IDLE;
      ren_B     <= 1'b0;
      addr_B    <= '0;
      mbr_out   <= '0;
      mbr_valid <= 1'b0;
    end else begin
      ren_B     <= 1'b0;
      mbr_valid <= 1'b0;
      case (state_b)
        B_IDLE: begin
          if (fetch_acc) begin
            addr_B <= pc;
            if (hazard_new) begin
              state_b <= B_PEND;
            end else begin
              state_b <= B_RD;
              ren_B   <= 1'b1;
            end
          end
        end
        B_PEND: begin
          if (!hazard_pend) begin
            state_b <= B_RD;
            ren_B   <= 1'b1;
          end
        end
        B_RD: state_b <= B_WAIT;
        B_WAIT: begin
          if (lat_b_done) begin
            state_b   <= B_IDLE;
            mbr_out   <= rdata_B;
            mbr_valid <= 1'b1;
          end
        end
        default: state_b <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_err <= 1'b0;
    end else begin
      req_err <= err_now;
    end
  end

  assign busy_a      = (state_a != A_IDLE);
  assign busy_b      = (state_b != B_IDLE);
  assign state_a_dbg = state_a;
  assign state_b_dbg = state_b;

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Directed bench for mic1_mem_ctrl: RD_LAT=1 and RD_LAT=3 instances share stimulus,
// each backed by its own main_memory model.
module tb_mic1_mem_ctrl;
  import mic1_mem_pkg::*;

  logic clk;
  logic rst_n;
  logic rd_req, wr_req, fetch_req;
  logic [8:0] mar, mdr_in, pc;

  logic [8:0] mdr_out1, mbr_out1, addr_A1, addr_B1, wdata_A1, rdata_A1, rdata_B1;
  logic mdr_valid1, mbr_valid1, wr_done1, busy_a1, busy_b1, req_err1, wen_A1, ren_A1, ren_B1;
  port_a_state_t sa1;
  port_b_state_t sb1;

  logic [8:0] mdr_out3, mbr_out3, addr_A3, addr_B3, wdata_A3, rdata_A3, rdata_B3;
  logic mdr_valid3, mbr_valid3, wr_done3, busy_a3, busy_b3, req_err3, wen_A3, ren_A3, ren_B3;
  port_a_state_t sa3;
  port_b_state_t sb3;

  logic [8:0] mem1 [512];
  logic [8:0] mem3 [512];
  logic [8:0] pa3 [3];
  logic [8:0] pb3 [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mic1_mem_ctrl #(.ADDR_W(9), .DATA_W(9), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .fetch_req(fetch_req),
    .mar(mar), .mdr_in(mdr_in), .pc(pc),
    .mdr_out(mdr_out1), .mdr_valid(mdr_valid1), .mbr_out(mbr_out1), .mbr_valid(mbr_valid1),
    .wr_done(wr_done1), .busy_a(busy_a1), .busy_b(busy_b1), .req_err(req_err1),
    .wen_A(wen_A1), .ren_A(ren_A1), .ren_B(ren_B1), .addr_A(addr_A1), .addr_B(addr_B1),
    .wdata_A(wdata_A1), .rdata_A(rdata_A1), .rdata_B(rdata_B1),
    .state_a_dbg(sa1), .state_b_dbg(sb1)
  );

  mic1_mem_ctrl #(.ADDR_W(9), .DATA_W(9), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .fetch_req(fetch_req),
    .mar(mar), .mdr_in(mdr_in), .pc(pc),
    .mdr_out(mdr_out3), .mdr_valid(mdr_valid3), .mbr_out(mbr_out3), .mbr_valid(mbr_valid3),
    .wr_done(wr_done3), .busy_a(busy_a3), .busy_b(busy_b3), .req_err(req_err3),
    .wen_A(wen_A3), .ren_A(ren_A3), .ren_B(ren_B3), .addr_A(addr_A3), .addr_B(addr_B3),
    .wdata_A(wdata_A3), .rdata_A(rdata_A3), .rdata_B(rdata_B3),
    .state_a_dbg(sa3), .state_b_dbg(sb3)
  );

  // main_memory models: write at the edge, read data RD_LAT cycles after ren is sampled
  always @(posedge clk) begin
    if (wen_A1) mem1[addr_A1] <= wdata_A1;
    if (ren_A1) rdata_A1 <= mem1[addr_A1];
    if (ren_B1) rdata_B1 <= mem1[addr_B1];
  end

  always @(posedge clk) begin
    if (wen_A3) mem3[addr_A3] <= wdata_A3;
    if (ren_A3) pa3[0] <= mem3[addr_A3];
    if (ren_B3) pb3[0] <= mem3[addr_B3];
    pa3[1] <= pa3[0];
    pa3[2] <= pa3[1];
    pb3[1] <= pb3[0];
    pb3[2] <= pb3[1];
  end
  assign rdata_A3 = pa3[2];
  assign rdata_B3 = pb3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0;
    wr_req = 1'b0;
    fetch_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mar = '0;
    mdr_in = '0;
    pc = '0;
    rdata_A1 = '0;
    rdata_B1 = '0;
    for (int i = 0; i < 3; i++) begin
      pa3[i] = '0;
      pb3[i] = '0;
    end
    for (int i = 0; i < 512; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    for (int i = 0; i < 5; i++) begin
      mem1[5 + i] = 9'(9'h0AA + 9'(i * 9'h011));
      mem3[5 + i] = 9'(9'h0AA + 9'(i * 9'h011));
    end

    // reset state
    tick();
    tick();
    check("rst_ren_A", ren_A1, 0);
    check("rst_wen_A", wen_A1, 0);
    check("rst_ren_B", ren_B1, 0);
    check("rst_busy_a", busy_a1, 0);
    check("rst_busy_b", busy_b1, 0);
    check("rst_mdr_out", mdr_out1, 0);
    check("rst_mbr_out", mbr_out1, 0);
    check("rst_addr_A", addr_A1, 0);
    check("rst_wdata_A", wdata_A1, 0);
    check("rst_req_err", req_err1, 0);
    rst_n = 1'b1;
    tick();

    // read 7, RD_LAT=1
    rd_req = 1'b1; mar = 9'd7;
    tick();
    check("rd7_ren_A_e0", ren_A1, 1);
    check("rd7_addr_A", addr_A1, 7);
    check("rd7_busy_e0", busy_a1, 1);
    check("rd7_valid_e0", mdr_valid1, 0);
    idle_inputs();
    tick();
    check("rd7_ren_A_e1", ren_A1, 0);
    check("rd7_busy_e1", busy_a1, 1);
    check("rd7_valid_e1", mdr_valid1, 0);
    tick();
    check("rd7_valid_e2", mdr_valid1, 1);
    check("rd7_mdr_e2", mdr_out1, 9'h0CC);
    check("rd7_busy_e2", busy_a1, 0);
    tick();
    check("rd7_valid_e3", mdr_valid1, 0);
    check("rd7_mdr_hold", mdr_out1, 9'h0CC);
    repeat (4) tick();

    // write 2 <= 1FF, then read it back
    wr_req = 1'b1; mar = 9'd2; mdr_in = 9'h1FF;
    tick();
    check("wr2_wen_A", wen_A1, 1);
    check("wr2_addr_A", addr_A1, 2);
    check("wr2_wdata_A", wdata_A1, 9'h1FF);
    check("wr2_ren_A", ren_A1, 0);
    idle_inputs();
    tick();
    check("wr2_wen_A_e1", wen_A1, 0);
    check("wr2_done_e1", wr_done1, 1);
    check("wr2_busy_e1", busy_a1, 0);
    tick();
    check("wr2_done_e2", wr_done1, 0);
    rd_req = 1'b1; mar = 9'd2;
    tick();
    idle_inputs();
    tick();
    tick();
    check("rd2_valid", mdr_valid1, 1);
    check("rd2_mdr", mdr_out1, 9'h1FF);
    repeat (4) tick();

    // fetch 3 alongside write 3 <= 055: fetch parks one cycle
    wr_req = 1'b1; mar = 9'd3; mdr_in = 9'h055;
    fetch_req = 1'b1; pc = 9'd3;
    tick();
    check("hz_wen_A_e0", wen_A1, 1);
    check("hz_ren_B_e0", ren_B1, 0);
    check("hz_busy_b_e0", busy_b1, 1);
    check("hz_state_b_e0", sb1, B_PEND);
    idle_inputs();
    tick();
    check("hz_wen_A_e1", wen_A1, 0);
    check("hz_ren_B_e1", ren_B1, 1);
    check("hz_addr_B", addr_B1, 3);
    tick();
    check("hz_ren_B_e2", ren_B1, 0);
    check("hz_mbr_valid_e2", mbr_valid1, 0);
    tick();
    check("hz_mbr_valid_e3", mbr_valid1, 1);
    check("hz_mbr_out", mbr_out1, 9'h055);
    repeat (5) tick();

    // fetch 4 alongside write 3: no stall, strobes concurrent
    wr_req = 1'b1; mar = 9'd3; mdr_in = 9'h066;
    fetch_req = 1'b1; pc = 9'd4;
    tick();
    check("nhz_wen_A_e0", wen_A1, 1);
    check("nhz_ren_B_e0", ren_B1, 1);
    check("nhz_addr_B", addr_B1, 4);
    idle_inputs();
    tick();
    tick();
    check("nhz_mbr_valid", mbr_valid1, 1);
    check("nhz_mbr_out", mbr_out1, 9'h000);
    repeat (5) tick();

    // rd and wr together: both ignored
    rd_req = 1'b1; wr_req = 1'b1; mar = 9'd5; mdr_in = 9'h111;
    tick();
    check("clash_req_err", req_err1, 1);
    check("clash_ren_A", ren_A1, 0);
    check("clash_wen_A", wen_A1, 0);
    check("clash_busy_a", busy_a1, 0);
    idle_inputs();
    tick();
    check("clash_req_err_clr", req_err1, 0);
    repeat (3) tick();

    // read while busy: dropped, first read completes
    rd_req = 1'b1; mar = 9'd6;
    tick();
    mar = 9'd8;
    tick();
    check("busy_req_err", req_err1, 1);
    check("busy_addr_A", addr_A1, 6);
    idle_inputs();
    tick();
    check("busy_mdr_valid", mdr_valid1, 1);
    check("busy_mdr_out", mdr_out1, 9'h0BB);
    repeat (5) tick();

    // reset during A_WAIT
    rd_req = 1'b1; mar = 9'd7;
    tick();
    idle_inputs();
    tick();
    check("mid_state_a", sa1, A_WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_mdr_out", mdr_out1, 0);
    check("mid_busy_a", busy_a1, 0);
    check("mid_mbr_out", mbr_out1, 0);
    check("mid_addr_A", addr_A1, 0);
    check("mid_wdata_A", wdata_A1, 0);
    tick();
    check("mid_no_valid", mdr_valid1, 0);
    rst_n = 1'b1;
    tick();
    check("mid_no_valid_after", mdr_valid1, 0);
    rd_req = 1'b1; mar = 9'd5;
    tick();
    idle_inputs();
    tick();
    tick();
    check("post_rst_valid", mdr_valid1, 1);
    check("post_rst_mdr", mdr_out1, 9'h0AA);
    repeat (5) tick();

    // RD_LAT=3 instance: read 7
    rd_req = 1'b1; mar = 9'd7;
    tick();
    check("l3_rd_ren_A", ren_A3, 1);
    check("l3_rd_busy_e0", busy_a3, 1);
    idle_inputs();
    tick();
    check("l3_rd_busy_e1", busy_a3, 1);
    check("l3_rd_ren_A_e1", ren_A3, 0);
    tick();
    check("l3_rd_busy_e2", busy_a3, 1);
    tick();
    check("l3_rd_busy_e3", busy_a3, 1);
    check("l3_rd_valid_e3", mdr_valid3, 0);
    tick();
    check("l3_rd_valid_e4", mdr_valid3, 1);
    check("l3_rd_mdr", mdr_out3, 9'h0CC);
    check("l3_rd_busy_e4", busy_a3, 0);
    repeat (2) tick();

    // RD_LAT=3: write 2 <= 123, read back
    wr_req = 1'b1; mar = 9'd2; mdr_in = 9'h123;
    tick();
    check("l3_wr_wen_A", wen_A3, 1);
    check("l3_wr_wdata_A", wdata_A3, 9'h123);
    idle_inputs();
    tick();
    check("l3_wr_done", wr_done3, 1);
    check("l3_wr_busy", busy_a3, 0);
    rd_req = 1'b1; mar = 9'd2;
    tick();
    idle_inputs();
    repeat (3) tick();
    check("l3_rd2_valid_e3", mdr_valid3, 0);
    tick();
    check("l3_rd2_valid_e4", mdr_valid3, 1);
    check("l3_rd2_mdr", mdr_out3, 9'h123);
    repeat (2) tick();

    // RD_LAT=3: fetch hazard on address 3
    wr_req = 1'b1; mar = 9'd3; mdr_in = 9'h0AB;
    fetch_req = 1'b1; pc = 9'd3;
    tick();
    check("l3_hz_wen_A", wen_A3, 1);
    check("l3_hz_ren_B_e0", ren_B3, 0);
    idle_inputs();
    tick();
    check("l3_hz_ren_B_e1", ren_B3, 1);
    repeat (3) tick();
    check("l3_hz_valid_e4", mbr_valid3, 0);
    tick();
    check("l3_hz_valid_e5", mbr_valid3, 1);
    check("l3_hz_mbr", mbr_out3, 9'h0AB);
    repeat (2) tick();

    // RD_LAT=3: fetch 5 alongside write 3, no stall
    wr_req = 1'b1; mar = 9'd3; mdr_in = 9'h0BC;
    fetch_req = 1'b1; pc = 9'd5;
    tick();
    check("l3_nhz_wen_A", wen_A3, 1);
    check("l3_nhz_ren_B", ren_B3, 1);
    idle_inputs();
    repeat (4) tick();
    check("l3_nhz_valid", mbr_valid3, 1);
    check("l3_nhz_mbr", mbr_out3, 9'h0AA);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
